// File: rtl/wb_writeback_stage.sv
// MEM/WB pipeline register and write-back logic.
// Latches MEM-stage results, aligns and extends load data, selects the GRF
// write value and issues exactly one GRF write per retired instruction.
// Also keeps a free-running count of retired instructions.
module wb_writeback_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        flush,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic        m_reg_we,
    input  logic [4:0]  m_rd,
    input  logic [1:0]  m_wd_sel,
    input  logic [31:0] m_alu_out,
    input  logic [31:0] m_mem_rdata,
    input  logic [2:0]  m_load_type,
    output logic        grf_we,
    output logic [4:0]  grf_waddr,
    output logic [31:0] grf_wdata,
    output logic [31:0] grf_wpc,
    output logic        wb_valid,
    output logic [31:0] retired
);

    localparam logic [1:0] SEL_ALU  = 2'd0;
    localparam logic [1:0] SEL_LOAD = 2'd1;
    localparam logic [1:0] SEL_LINK = 2'd2;

    localparam logic [2:0] LT_LB  = 3'd1;
    localparam logic [2:0] LT_LBU = 3'd2;
    localparam logic [2:0] LT_LH  = 3'd3;
    localparam logic [2:0] LT_LHU = 3'd4;

    // MEM/WB register contents
    logic        r_valid;
    logic [31:0] r_pc;
    logic        r_reg_we;
    logic [4:0]  r_rd;
    logic [1:0]  r_wd_sel;
    logic [31:0] r_alu_out;
    logic [31:0] r_mem_rdata;
    logic [2:0]  r_load_type;
    // Set once the held instruction has had its single write/retire opportunity
    logic        r_written;
    logic [31:0] r_retired;

    logic [7:0]  w_byte_lane [4];
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_wdata;
    logic        w_retire;

    // Pipeline register: rst > flush > hold > load
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_pc        <= RESET_PC;
            r_reg_we    <= 1'b0;
            r_rd        <= 5'd0;
            r_wd_sel    <= 2'd0;
            r_alu_out   <= 32'd0;
            r_mem_rdata <= 32'd0;
            r_load_type <= 3'd0;
            r_written   <= 1'b0;
        end else if (flush) begin
            // Bubble: the payload fields are don't-care once valid drops
            r_valid   <= 1'b0;
            r_written <= 1'b0;
        end else if (hold) begin
            // A held real instruction has now used its one write/retire slot
            if (r_valid) begin
                r_written <= 1'b1;
            end
        end else begin
            r_valid     <= m_valid;
            r_pc        <= m_pc;
            r_reg_we    <= m_reg_we;
            r_rd        <= m_rd;
            r_wd_sel    <= m_wd_sel;
            r_alu_out   <= m_alu_out;
            r_mem_rdata <= m_mem_rdata;
            r_load_type <= m_load_type;
            r_written   <= 1'b0;
        end
    end

    assign w_retire = r_valid & ~r_written;

    // Retired-instruction counter: one count per instruction, wraps mod 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired <= 32'd0;
        end else if (w_retire) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    // Split the loaded word into its four byte lanes
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_byte_lane[gi] = r_mem_rdata[8*gi +: 8];
        end
    endgenerate

    assign w_byte = w_byte_lane[r_alu_out[1:0]];
    // Halfword selection ignores the low address bit (misaligned halves not supported)
    assign w_half = r_alu_out[1] ? r_mem_rdata[31:16] : r_mem_rdata[15:0];

    // Load alignment and sign/zero extension; unknown types behave as lw
    always_comb begin
        w_load_data = r_mem_rdata;
        case (r_load_type)
            LT_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
            LT_LBU:  w_load_data = {24'd0, w_byte};
            LT_LH:   w_load_data = {{16{w_half[15]}}, w_half};
            LT_LHU:  w_load_data = {16'd0, w_half};
            default: w_load_data = r_mem_rdata;
        endcase
    end

    // Write-value select; the reserved encoding writes zero and never enables a write
    always_comb begin
        w_wdata = 32'd0;
        case (r_wd_sel)
            SEL_ALU:  w_wdata = r_alu_out;
            SEL_LOAD: w_wdata = w_load_data;
            SEL_LINK: w_wdata = r_pc + 32'd8;
            default:  w_wdata = 32'd0;
        endcase
    end

    assign grf_we    = r_valid & r_reg_we & (r_rd != 5'd0) & (r_wd_sel != 2'd3) & ~r_written;
    assign grf_waddr = r_rd;
    assign grf_wdata = w_wdata;
    assign grf_wpc   = r_pc;
    assign wb_valid  = r_valid;
    assign retired   = r_retired;

endmodule

// File: tb/tb_wb_writeback_stage.sv
// Self-checking bench for wb_writeback_stage: directed corner cases, a
// load-extension vector table and randomized traffic against a reference model.
module tb_wb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst, hold, flush, m_valid, m_reg_we;
    logic [31:0] m_pc, m_alu_out, m_mem_rdata;
    logic [4:0]  m_rd;
    logic [1:0]  m_wd_sel;
    logic [2:0]  m_load_type;
    logic        grf_we, wb_valid;
    logic [4:0]  grf_waddr;
    logic [31:0] grf_wdata, grf_wpc, retired;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_writeback_stage #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .m_valid(m_valid), .m_pc(m_pc), .m_reg_we(m_reg_we), .m_rd(m_rd),
        .m_wd_sel(m_wd_sel), .m_alu_out(m_alu_out), .m_mem_rdata(m_mem_rdata),
        .m_load_type(m_load_type),
        .grf_we(grf_we), .grf_waddr(grf_waddr), .grf_wdata(grf_wdata),
        .grf_wpc(grf_wpc), .wb_valid(wb_valid), .retired(retired)
    );

    // Reference model: the instruction currently in write-back, whether it
    // has already had its turn, and the number of instructions retired.
    logic        md_valid, md_we, md_done;
    logic [31:0] md_pc, md_alu, md_rdata, md_ret;
    logic [4:0]  md_rd;
    logic [1:0]  md_sel;
    logic [2:0]  md_lt;

    function automatic logic [31:0] ref_load(input logic [2:0] lt, input logic [31:0] alu,
                                             input logic [31:0] rdata);
        int unsigned a, b, h;
        a = alu % 4;
        b = (rdata >> (8 * a)) % 256;
        h = (rdata >> (16 * (a / 2))) % 65536;
        case (lt)
            3'd1: return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
            3'd2: return 32'(b);
            3'd3: return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
            3'd4: return 32'(h);
            default: return rdata;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata();
        case (md_sel)
            2'd0: return md_alu;
            2'd1: return ref_load(md_lt, md_alu, md_rdata);
            2'd2: return md_pc + 32'd8;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_we();
        return md_valid && md_we && md_rd != 0 && md_sel != 2'd3 && !md_done;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_edge();
        if (rst) begin
            md_valid = 0; md_we = 0; md_done = 0; md_pc = 32'h3000; md_alu = 0;
            md_rdata = 0; md_rd = 0; md_sel = 0; md_lt = 0; md_ret = 0;
        end else begin
            if (md_valid && !md_done) md_ret = md_ret + 1;
            if (flush) begin
                md_valid = 0; md_done = 0;
            end else if (hold) begin
                if (md_valid) md_done = 1;
            end else begin
                md_valid = m_valid; md_we = m_reg_we; md_pc = m_pc; md_rd = m_rd;
                md_sel = m_wd_sel; md_alu = m_alu_out; md_rdata = m_mem_rdata;
                md_lt = m_load_type; md_done = 0;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model();
        chk("wb_valid", 32'(wb_valid), 32'(md_valid));
        chk("grf_we", 32'(grf_we), 32'(ref_we()));
        chk("retired", retired, md_ret);
        if (md_valid) begin
            chk("grf_waddr", 32'(grf_waddr), 32'(md_rd));
            chk("grf_wpc", grf_wpc, md_pc);
            chk("grf_wdata", grf_wdata, ref_wdata());
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                         input logic [1:0] sel, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic [2:0] lt,
                         input logic [31:0] pc);
        m_valid = v; m_reg_we = we; m_rd = rd; m_wd_sel = sel;
        m_alu_out = alu; m_mem_rdata = rdata; m_load_type = lt; m_pc = pc;
    endtask

    task automatic bubble();
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    typedef struct {
        logic [2:0]  lt;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] exp;
    } load_vec_t;

    load_vec_t vecs [13];

    initial begin
        vecs[0]  = '{3'd1, 32'h0000_1003, 32'h80FF_7F01, 32'hFFFF_FF80};
        vecs[1]  = '{3'd2, 32'h0000_1003, 32'h80FF_7F01, 32'h0000_0080};
        vecs[2]  = '{3'd3, 32'h0000_1002, 32'h80FF_7F01, 32'hFFFF_80FF};
        vecs[3]  = '{3'd4, 32'h0000_1002, 32'h80FF_7F01, 32'h0000_80FF};
        vecs[4]  = '{3'd0, 32'h0000_1003, 32'h80FF_7F01, 32'h80FF_7F01};
        vecs[5]  = '{3'd1, 32'h0000_1000, 32'h80FF_7F01, 32'h0000_0001};
        vecs[6]  = '{3'd1, 32'h0000_1001, 32'h80FF_7F01, 32'h0000_007F};
        vecs[7]  = '{3'd2, 32'h0000_1002, 32'h80FF_7F01, 32'h0000_00FF};
        vecs[8]  = '{3'd1, 32'h0000_1002, 32'h80FF_7F01, 32'hFFFF_FFFF};
        vecs[9]  = '{3'd3, 32'h0000_1001, 32'h80FF_7F01, 32'h0000_7F01};
        vecs[10] = '{3'd4, 32'h0000_1003, 32'h80FF_7F01, 32'h0000_80FF};
        vecs[11] = '{3'd5, 32'h0000_1002, 32'h80FF_7F01, 32'h80FF_7F01};
        vecs[12] = '{3'd7, 32'h0000_1001, 32'h1234_5678, 32'h1234_5678};

        rst = 1; hold = 0; flush = 0;
        bubble();
        #1;
        tick();
        tick();

        // Reset values
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_grf_we", 32'(grf_we), 32'd0);
        chk("rst_grf_waddr", 32'(grf_waddr), 32'd0);
        chk("rst_grf_wdata", grf_wdata, 32'd0);
        chk("rst_grf_wpc", grf_wpc, 32'h0000_3000);
        chk("rst_retired", retired, 32'd0);
        rst = 0;

        // Basic ALU write, one-cycle latency
        drive(1, 1, 5'd5, 2'd0, 32'h1234_5678, 32'h0, 3'd0, 32'h0000_3000);
        tick();
        bubble();
        chk("t1_grf_we", 32'(grf_we), 32'd1);
        chk("t1_grf_waddr", 32'(grf_waddr), 32'd5);
        chk("t1_grf_wdata", grf_wdata, 32'h1234_5678);
        chk("t1_grf_wpc", grf_wpc, 32'h0000_3000);
        tick();
        chk("t1_retired", retired, 32'd1);
        chk("t1_bubble_we", 32'(grf_we), 32'd0);

        // Load extension table
        for (int i = 0; i < 13; i++) begin
            drive(1, 1, 5'd3, 2'd1, vecs[i].alu, vecs[i].rdata, vecs[i].lt, 32'h0000_3100 + 32'(4 * i));
            tick();
            chk($sformatf("tbl%0d_wdata", i), grf_wdata, vecs[i].exp);
            check_model();
        end

        // jal link value, then rd=0 variant counts but does not write
        drive(1, 1, 5'd31, 2'd2, 32'h0, 32'h0, 3'd0, 32'h0000_3010);
        tick();
        chk("t3_wdata", grf_wdata, 32'h0000_3018);
        chk("t3_we", 32'(grf_we), 32'd1);
        chk("t3_waddr", 32'(grf_waddr), 32'd31);
        drive(1, 1, 5'd0, 2'd2, 32'h0, 32'h0, 3'd0, 32'h0000_3014);
        tick();
        chk("t3_rd0_we", 32'(grf_we), 32'd0);
        check_model();
        bubble();
        tick();
        chk("t3_retired", retired, 32'd16);

        // Held load writes once, outputs stable, counted once
        drive(1, 1, 5'd7, 2'd1, 32'h0000_2001, 32'hAABB_CCDD, 3'd1, 32'h0000_3200);
        tick();
        chk("t4_we_first", 32'(grf_we), 32'd1);
        chk("t4_wdata_first", grf_wdata, 32'hFFFF_FFCC);
        hold = 1;
        bubble();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t4_we_held%0d", i), 32'(grf_we), 32'd0);
            chk($sformatf("t4_wdata_held%0d", i), grf_wdata, 32'hFFFF_FFCC);
            chk($sformatf("t4_waddr_held%0d", i), 32'(grf_waddr), 32'd7);
            chk($sformatf("t4_retired_held%0d", i), retired, 32'd17);
        end

        // flush beats hold; an already-retired held instruction is not recounted
        flush = 1;
        drive(1, 1, 5'd9, 2'd0, 32'h5555_0000, 32'h0, 3'd0, 32'h0000_3300);
        tick();
        flush = 0; hold = 0;
        bubble();
        chk("t5_wb_valid", 32'(wb_valid), 32'd0);
        chk("t5_we", 32'(grf_we), 32'd0);
        chk("t5_retired", retired, 32'd17);

        // Counter wrap
        force dut.r_retired = 32'hFFFF_FFFF;
        #1;
        release dut.r_retired;
        md_ret = 32'hFFFF_FFFF;
        drive(1, 0, 5'd0, 2'd0, 32'h0, 32'h0, 3'd0, 32'h0000_3400);
        tick();
        bubble();
        tick();
        chk("t6_wrap", retired, 32'd0);

        // Reset during hold discards the held instruction
        drive(1, 1, 5'd12, 2'd0, 32'hDEAD_BEEF, 32'h0, 3'd0, 32'h0000_3500);
        tick();
        hold = 1;
        bubble();
        tick();
        rst = 1;
        tick();
        rst = 0; hold = 0;
        chk("t6_rst_valid", 32'(wb_valid), 32'd0);
        chk("t6_rst_we", 32'(grf_we), 32'd0);
        chk("t6_rst_waddr", 32'(grf_waddr), 32'd0);
        chk("t6_rst_wdata", grf_wdata, 32'd0);
        chk("t6_rst_wpc", grf_wpc, 32'h0000_3000);
        chk("t6_rst_retired", retired, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 99) < 3);
            flush = ($urandom_range(0, 99) < 10);
            hold  = ($urandom_range(0, 99) < 30);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom_range(0, 31)),
                  2'($urandom_range(0, 3)), $urandom, $urandom, 3'($urandom_range(0, 7)),
                  $urandom);
            tick();
            check_model();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
